// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multicycle RV32I control path
package riscv_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_src_t;
  typedef enum logic [1:0] {A_PC = 2'b00, A_OLDPC = 2'b01, A_RD1 = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {B_RD2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
  typedef enum logic [1:0] {AOP_ADD = 2'b00, AOP_SUB = 2'b01, AOP_FUNCT = 2'b10} alu_op_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps operation class plus funct fields to the ALU operation code
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_operation
);
  // op5 separates R-type from addi, which must ignore funct7b5
  always_comb
    alu_operation = alu_op == AOP_SUB ? ALU_SUB :
                    alu_op == AOP_ADD ? ALU_ADD :
                    funct3 == 3'b111 ? ALU_AND :
                    funct3 == 3'b110 ? ALU_OR :
                    (funct3 == 3'b000 && op5 && funct7b5) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM stepping RV32I instructions through fetch..writeback
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [3:0] ALU_Operation,
  output logic [3:0] state
);
  state_t state_q, state_n;
  logic pc_update, branch, ir_w, reg_w, mem_w;
  alu_op_t alu_op;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_FETCH;
    else state_q <= state_n;
  always_comb begin
    state_n = S_FETCH;
    case (state_q)
      S_FETCH:    state_n = S_DECODE;
      S_DECODE:   state_n = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                            opcode == OP_R   ? S_EXECUTER :
                            opcode == OP_I   ? S_EXECUTEI :
                            opcode == OP_BEQ ? S_BEQ :
                            opcode == OP_JAL ? S_JAL : S_FETCH;
      S_MEMADR:   state_n = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_n = S_MEMWB;
      S_EXECUTER: state_n = S_ALUWB;
      S_EXECUTEI: state_n = S_ALUWB;
      S_JAL:      state_n = S_ALUWB;
      default:    state_n = S_FETCH;
    endcase
  end
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = A_PC;
    alu_src_b  = B_RD2;
    alu_op     = AOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_w       = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = A_RD1;
        alu_src_b = B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = A_RD1;
        alu_op    = AOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = A_RD1;
        alu_src_b = B_IMM;
        alu_op    = AOP_FUNCT;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BEQ: begin
        alu_src_a = A_RD1;
        alu_op    = AOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb
    imm_src = opcode == OP_SW ? IMM_S : opcode == OP_BEQ ? IMM_B : opcode == OP_JAL ? IMM_J : IMM_I;
  // reset blocks every strobe combinationally so an aborted instruction writes nothing
  assign pc_write  = ~rst & (pc_update | (branch & zero));
  assign ir_write  = ~rst & ir_w;
  assign reg_write = ~rst & reg_w;
  assign mem_write = ~rst & mem_w;
  assign state     = state_q;
  alu_decoder u_alu_decoder (
    .alu_op       (alu_op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .op5          (opcode[5]),
    .alu_operation(ALU_Operation)
  );
endmodule
